// File: rtl/rf_pkg.sv
// Shared register-file types and constants used by decode, writeback and the register file.
package rf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write busy bits with set-over-clear priority and per-port hazard lookup.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_reg,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD-1:0]        read_busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (reset) begin
      busy_d = '0;
    end else begin
      if (reg_write && write_reg != ZERO_A) busy_d[write_reg] = 1'b0;
      // Applied after the clear: a newer producer supersedes the retiring one.
      if (issue_valid && issue_reg != ZERO_A) busy_d[issue_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) busy_q <= busy_d;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic              fwd;
    assign addr = read_reg[i*ADDR_W +: ADDR_W];
    assign fwd  = (BYPASS != 0) && reg_write && !reset && (write_reg == addr);
    assign read_busy[i] = busy_q[addr] & ~fwd;
  end
endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file: zero register, optional write bypass, pending-write scoreboard.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] data_reg,
  output logic [NUM_RD-1:0]        read_busy,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_reg
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic                         wr_en;

  assign wr_en = reg_write && !reset && (write_reg != ZERO_A);

  always_comb begin
    mem_d = mem_q;
    if (reset) mem_d = '0;
    else if (wr_en) mem_d[write_reg] = write_data;
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              fwd;
    assign addr = read_reg[i*ADDR_W +: ADDR_W];
    assign fwd  = (BYPASS != 0) && wr_en && (write_reg == addr);
    always_comb begin
      data_reg[i*DATA_W +: DATA_W] = mem_q[addr];
      if (addr == ZERO_A)  data_reg[i*DATA_W +: DATA_W] = '0;
      else if (fwd)        data_reg[i*DATA_W +: DATA_W] = write_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .read_reg    (read_reg),
    .read_busy   (read_busy)
  );
endmodule
